// File: rtl/vx_index_arbiter.sv
// vx_index_arbiter: round-robin allocator of index-buffer slots with per-requester occupancy limits
module vx_index_arbiter #(
  parameter int NUM_REQS    = 4,
  parameter int DATAW       = 32,
  parameter int SIZE        = 8,
  parameter int MAX_PENDING = 4,
  localparam int CNTW  = (MAX_PENDING + 1 > 1) ? $clog2(MAX_PENDING + 1) : 1,
  localparam int ADDRW = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int REQW  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQS-1:0]      req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]      req_ready,
  output logic                     grant_valid,
  output logic [REQW-1:0]          grant_req,
  output logic [ADDRW-1:0]         grant_addr,
  output logic                     buf_acquire,
  output logic [DATAW-1:0]         buf_write_data,
  input  logic [ADDRW-1:0]         buf_write_addr,
  input  logic                     buf_full,
  input  logic                     rel_valid,
  input  logic [ADDRW-1:0]         rel_addr,
  output logic                     buf_release_slot,
  output logic [ADDRW-1:0]         buf_release_addr,
  output logic [NUM_REQS*CNTW-1:0] pending_cnt,
  output logic                     err_release
);
  logic [REQW-1:0]     ptr;
  logic [CNTW-1:0]     cnt [NUM_REQS];
  logic [SIZE-1:0]     owner_vld;
  logic [REQW-1:0]     owner_id [SIZE];
  logic [NUM_REQS-1:0] elig, gnt;
  logic [REQW-1:0]     gidx;
  logic                hs, rel_hit;
  // a requester may compete only while it is below its occupancy limit
  always_comb begin
    for (int r = 0; r < NUM_REQS; r++) elig[r] = req_valid[r] && (cnt[r] < CNTW'(MAX_PENDING));
  end
  // rotating priority search from ptr; scanning backwards lets the nearest eligible index win
  always_comb begin
    gnt  = '0;
    gidx = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(ptr) + k) % NUM_REQS;
      if (elig[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gidx     = REQW'(idx);
      end
    end
    if (!reset_n || buf_full) gnt = '0;
  end
  assign hs               = |gnt;
  assign req_ready        = gnt;
  assign buf_acquire      = hs;
  assign buf_write_data   = req_data[gidx*DATAW +: DATAW];
  assign buf_release_slot = rel_valid & reset_n;
  assign buf_release_addr = rel_addr;
  assign rel_hit          = rel_valid && owner_vld[rel_addr];
  for (genvar g = 0; g < NUM_REQS; g++) begin : g_cnt
    assign pending_cnt[g*CNTW +: CNTW] = cnt[g];
  end
  // slot validity: release clears first so an acquire of the same slot wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) owner_vld <= '0;
    else begin
      if (rel_hit) owner_vld[rel_addr] <= 1'b0;
      if (hs) owner_vld[buf_write_addr] <= 1'b1;
    end
  end
  // owner ids are only meaningful where owner_vld is set, so they need no reset
  always_ff @(posedge clk) begin
    if (hs) owner_id[buf_write_addr] <= gidx;
  end
  // per-requester held counts; simultaneous acquire and release by one owner cancel out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) for (int r = 0; r < NUM_REQS; r++) cnt[r] <= '0;
    else for (int r = 0; r < NUM_REQS; r++)
      cnt[r] <= cnt[r] + CNTW'(hs && gidx == REQW'(r)) - CNTW'(rel_hit && owner_id[rel_addr] == REQW'(r));
  end
  // round-robin pointer, grant pulse and sticky illegal-release flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      grant_valid <= 1'b0;
      grant_req   <= '0;
      grant_addr  <= '0;
      err_release <= 1'b0;
    end else begin
      grant_valid <= hs;
      if (hs) begin
        ptr        <= (gidx == REQW'(NUM_REQS - 1)) ? '0 : gidx + 1'b1;
        grant_req  <= gidx;
        grant_addr <= buf_write_addr;
      end
      if (rel_valid && !owner_vld[rel_addr]) err_release <= 1'b1;
    end
  end
endmodule

// File: tb/tb_vx_index_arbiter.sv
// tb_vx_index_arbiter: table, directed and randomized checks against a slot-ownership model
module tb_vx_index_arbiter;
  localparam int N = 4, DW = 32, SZ = 8, MP = 4, CW = 3, AW = 3, RW = 2;
  logic clk = 0, reset_n = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic grant_valid, buf_acquire, buf_full = 0, rel_valid = 0, buf_release_slot, err_release;
  logic [RW-1:0] grant_req;
  logic [AW-1:0] grant_addr, buf_write_addr = '0, rel_addr = '0, buf_release_addr;
  logic [DW-1:0] buf_write_data;
  logic [N*CW-1:0] pending_cnt;
  int n_checks = 0, n_err = 0;
  int m_owner [SZ];
  int m_cnt [N];
  int m_ptr, m_greq, m_gaddr;
  bit m_err, m_gv;
  typedef struct { logic [N-1:0] rv; bit full; int waddr; logic [N-1:0] exp_ready; } vec_t;
  vec_t tbl [7];

  vx_index_arbiter #(.NUM_REQS(N), .DATAW(DW), .SIZE(SZ), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_valid(grant_valid), .grant_req(grant_req), .grant_addr(grant_addr), .buf_acquire(buf_acquire),
    .buf_write_data(buf_write_data), .buf_write_addr(buf_write_addr), .buf_full(buf_full),
    .rel_valid(rel_valid), .rel_addr(rel_addr), .buf_release_slot(buf_release_slot),
    .buf_release_addr(buf_release_addr), .pending_cnt(pending_cnt), .err_release(err_release));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < SZ; s++) m_owner[s] = -1;
    for (int r = 0; r < N; r++) m_cnt[r] = 0;
    m_ptr = 0; m_err = 0; m_gv = 0; m_greq = 0; m_gaddr = 0;
  endfunction

  function automatic int pick(input logic [N-1:0] rv, input bit full);
    if (full) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (rv[i] && m_cnt[i] < MP) return i;
    end
    return -1;
  endfunction

  task automatic check_regs();
    chk("grant_valid", grant_valid, m_gv);
    if (m_gv) begin
      chk("grant_req", grant_req, m_greq);
      chk("grant_addr", grant_addr, m_gaddr);
    end
    for (int r = 0; r < N; r++) chk($sformatf("pending_cnt[%0d]", r), pending_cnt[r*CW +: CW], m_cnt[r]);
    chk("err_release", err_release, m_err);
  endtask

  // called at a negedge; drives one cycle, checks combinational then registered outputs
  task automatic step(input logic [N-1:0] rv, input bit full, input int waddr, input bit rel, input int raddr);
    int g;
    req_valid = rv; buf_full = full; buf_write_addr = AW'(waddr); rel_valid = rel; rel_addr = AW'(raddr);
    for (int r = 0; r < N; r++) req_data[r*DW +: DW] = $urandom;
    #1;
    g = pick(rv, full);
    chk("req_ready", req_ready, g >= 0 ? (1 << g) : 0);
    chk("buf_acquire", buf_acquire, g >= 0);
    if (g >= 0) chk("buf_write_data", buf_write_data, req_data[g*DW +: DW]);
    chk("buf_release_slot", buf_release_slot, rel);
    if (rel) chk("buf_release_addr", buf_release_addr, raddr);
    if (rel) begin
      if (m_owner[raddr] >= 0) begin m_cnt[m_owner[raddr]]--; m_owner[raddr] = -1; end
      else m_err = 1;
    end
    m_gv = g >= 0;
    if (g >= 0) begin
      m_owner[waddr] = g; m_cnt[g]++; m_ptr = (g + 1) % N; m_greq = g; m_gaddr = waddr;
    end
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 0; req_valid = '1; rel_valid = 1; rel_addr = 0; buf_full = 0;
    #1;
    model_reset();
    chk("rst req_ready", req_ready, 0);
    chk("rst buf_acquire", buf_acquire, 0);
    chk("rst buf_release_slot", buf_release_slot, 0);
    check_regs();
    chk("rst grant_req", grant_req, 0);
    chk("rst grant_addr", grant_addr, 0);
    @(posedge clk); #1;
    check_regs();
    @(negedge clk);
    req_valid = '0; rel_valid = 0; reset_n = 1;
  endtask

  initial begin
    tbl[0] = '{4'b1111, 0, 0, 4'b0001};
    tbl[1] = '{4'b1111, 0, 1, 4'b0010};
    tbl[2] = '{4'b1111, 0, 2, 4'b0100};
    tbl[3] = '{4'b1111, 0, 3, 4'b1000};
    tbl[4] = '{4'b1111, 1, 4, 4'b0000};
    tbl[5] = '{4'b1111, 1, 4, 4'b0000};
    tbl[6] = '{4'b1111, 0, 4, 4'b0001};
    @(negedge clk);
    do_reset();
    for (int t = 0; t < 7; t++) begin
      step(tbl[t].rv, tbl[t].full, tbl[t].waddr, 0, 0);
      chk($sformatf("tbl%0d grant_valid", t), grant_valid, tbl[t].exp_ready != 0);
    end
    // single requester saturates, then one release reopens it
    do_reset();
    for (int i = 0; i < 4; i++) step(4'b0100, 0, i, 0, 0);
    step(4'b0100, 0, 4, 0, 0);
    chk("sat pending2", pending_cnt[2*CW +: CW], 4);
    step(4'b0100, 0, 4, 1, 1);
    chk("after rel pending2", pending_cnt[2*CW +: CW], 3);
    step(4'b0100, 0, 4, 0, 0);
    chk("reopen grant_req", grant_req, 2);
    // release of a never-allocated slot
    do_reset();
    step(4'b0000, 0, 0, 1, 5);
    step(4'b0000, 0, 0, 0, 0);
    chk("err sticky", err_release, 1);
    // same-owner acquire plus release cancel
    do_reset();
    step(4'b0010, 0, 3, 0, 0);
    step(4'b0010, 0, 4, 1, 3);
    chk("swap pending1", pending_cnt[1*CW +: CW], 1);
    step(4'b0000, 0, 0, 1, 4);
    step(4'b0000, 0, 0, 1, 3);
    chk("slot3 was freed", err_release, 1);
    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      int fr[$], ow[$];
      int wa, ra;
      bit fl, rl;
      for (int s = 0; s < SZ; s++) if (m_owner[s] < 0) fr.push_back(s); else ow.push_back(s);
      fl = fr.size() == 0 || $urandom_range(7) == 0;
      wa = fr.size() ? fr[$urandom_range(fr.size() - 1)] : $urandom_range(SZ - 1);
      rl = $urandom_range(2) == 0;
      ra = (ow.size() && $urandom_range(15) != 0) ? ow[$urandom_range(ow.size() - 1)] : $urandom_range(SZ - 1);
      step(N'($urandom), fl, wa, rl, ra);
      if (c == 200) do_reset();
    end
    // mid-traffic reset, then lowest eligible index wins
    step(4'b1111, 0, 0, 0, 0);
    do_reset();
    step(4'b1010, 0, 2, 0, 0);
    chk("post-reset grant_req", grant_req, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/vx_index_arbiter.md
VX_INDEX_ARBITER -- requirements
Module: VX_index_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQS, default 4, number of requesters sharing one index buffer.
REQ-002 SHALL have parameter DATAW, default 32, payload width written into the allocated slot.
REQ-003 SHALL have parameter SIZE, default 8, slot count of the managed index buffer.
REQ-004 SHALL have parameter MAX_PENDING, default 4, maximum slots one requester may hold; CNTW=LOG2UP(MAX_PENDING+1), ADDRW=LOG2UP(SIZE), REQW=LOG2UP(NUM_REQS).
REQ-005 SHALL have one clock and an asynchronous active-low reset, ports clk then reset_n:
- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous assert, active-low
- req_valid  in  NUM_REQS  per-requester allocate request
- req_data  in  NUM_REQS*DATAW  per-requester payload, requester i at bits [i*DATAW +: DATAW]
- req_ready  out  NUM_REQS  one-hot accept; handshake = valid & ready
- grant_valid  out  1  registered allocation result valid
- grant_req  out  REQW  requester that was granted
- grant_addr  out  ADDRW  slot index allocated
- buf_acquire  out  1  acquire strobe to index buffer
- buf_write_data  out  DATAW  payload to index buffer
- buf_write_addr  in  ADDRW  next free slot from index buffer
- buf_full  in  1  index buffer has no free slot
- rel_valid  in  1  release request
- rel_addr  in  ADDRW  slot to release
- buf_release_slot  out  1  release strobe to index buffer
- buf_release_addr  out  ADDRW  slot released
- pending_cnt  out  NUM_REQS*CNTW  slots held per requester
- err_release  out  1  sticky illegal-release flag

Function
REQ-006 Requester i SHALL be eligible when req_valid[i]=1 and its held count < MAX_PENDING.
REQ-007 When buf_full=0 and any requester eligible, exactly one req_ready bit SHALL assert combinationally in the same cycle, chosen round-robin.
REQ-008 Round-robin: search SHALL start at index ptr, ptr reset 0; after grant to i, ptr SHALL become (i+1) mod NUM_REQS; no grant leaves ptr unchanged.
REQ-009 When buf_full=1, req_ready SHALL be all-zero and buf_acquire 0.
REQ-010 On handshake of requester i: buf_acquire=1 same cycle, buf_write_data=req_data of i, owner[buf_write_addr] SHALL be set to i and marked valid at the clock edge.
REQ-011 Cycle after handshake: grant_valid=1, grant_req=i, grant_addr=value of buf_write_addr at handshake; otherwise grant_valid=0 (single-cycle pulse, no backpressure).
REQ-012 Releases SHALL always be accepted: buf_release_slot=rel_valid, buf_release_addr=rel_addr, combinational pass-through.
REQ-013 On rel_valid with owner[rel_addr] valid: owner entry SHALL be invalidated and held count of that owner decremented at the clock edge.
REQ-014 On rel_valid with owner[rel_addr] invalid: release SHALL still be forwarded, no count change, err_release SHALL set to 1 and hold until reset.
REQ-015 Same-cycle acquire and release by the same owner SHALL leave that count unchanged; different owners SHALL update independently.
REQ-016 Held counts SHALL never exceed MAX_PENDING nor underflow below 0.
REQ-017 Any requester holding valid continuously, with count < MAX_PENDING and buf_full=0, SHALL be granted within NUM_REQS cycles.
REQ-018 pending_cnt SHALL reflect registered counts (updated one edge after the event).

Reset
REQ-019 On reset_n=0, asynchronously: ptr=0, all counts 0, all owner entries invalid, grant_valid=0, grant_req=0, grant_addr=0, err_release=0.
REQ-020 During reset req_ready, buf_acquire, buf_release_slot SHALL be 0; releases arriving in reset SHALL be ignored for bookkeeping.
REQ-021 Reset asserted mid-operation SHALL discard all ownership; first grant after deassertion SHALL go to lowest eligible index from 0.

Verification
REQ-022 All four req_valid=1, buf_full=0, buf_write_addr=0,1,2,3 over cycles -> grants in order req 0,1,2,3, grant_addr 0,1,2,3, each one cycle after its ready.
REQ-023 Only req 2 valid, MAX_PENDING=4, no releases -> four grants, then req_ready[2]=0, pending_cnt[2]=4; one release of its slot -> next cycle count 3, req_ready[2]=1 again.
REQ-024 buf_full=1 with req_valid=4'b1111 -> req_ready=0, buf_acquire=0, grant_valid stays 0; deassert buf_full -> grant to requester at ptr.
REQ-025 rel_valid on never-allocated slot 5 -> buf_release_slot=1, addr 5, err_release=1 next cycle and held; all counts unchanged.
REQ-026 Req 1 holds slot 3; same cycle req 1 granted slot 4 and slot 3 released -> pending_cnt[1] unchanged; owner[3] invalid, owner[4]=1.
REQ-027 Reset_n pulsed low mid-traffic with counts nonzero -> all outputs/counts zero immediately; after release, req_valid=4'b1010 -> first grant to requester 1.
